// File: rtl/ofm_requant_packer.sv
// Drains the 16-bit OFM buffer after the array finishes, requantizes each element to
// 8 bits (rounding shift, optional ReLU, saturation) and emits 16-lane packed words.

module ofm_requant_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module ofm_requant_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int INOUT_WIDTH = 128,
  parameter int OFM_SIZE    = 32,
  parameter int NO_FILTER   = 32,
  parameter int ADDR_WIDTH  = 15,
  parameter int WADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              cfg_shift,
  input  logic                    cfg_relu,
  output logic                    ofm_rd_en,
  output logic [ADDR_WIDTH-1:0]   ofm_rd_addr,
  input  logic [2*DATA_WIDTH-1:0] ofm_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INOUT_WIDTH-1:0]  out_data,
  output logic [WADDR_WIDTH-1:0]  out_addr,
  output logic                    busy,
  output logic                    done
);
  localparam int LANES    = INOUT_WIDTH / DATA_WIDTH;
  localparam int LW       = $clog2(LANES);
  localparam int OW       = 2 * DATA_WIDTH;
  localparam int NO_ELEM  = OFM_SIZE * OFM_SIZE * NO_FILTER;
  localparam int NO_WORDS = NO_ELEM / LANES;
  localparam logic [ADDR_WIDTH-1:0]  ELEM_LAST = ADDR_WIDTH'(NO_ELEM - 1);
  localparam logic [WADDR_WIDTH-1:0] WORD_LAST = WADDR_WIDTH'(NO_WORDS - 1);
  localparam logic signed [OW:0] SAT_MAX = $signed({{(OW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [OW:0] SAT_MIN = $signed({{(OW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

  typedef enum logic [2:0] {IDLE, FILL, WAIT, HOLD, DONE} state_t;
  typedef struct packed {
    logic [3:0] shift;
    logic       relu;
  } cfg_t;

  state_t                              state, state_nxt;
  cfg_t                                cfg;
  logic [LW-1:0]                       lane, lane_d;
  logic [WADDR_WIDTH-1:0]              word;
  logic [ADDR_WIDTH-1:0]               elem;
  logic                                rd_vld;
  logic [DATA_WIDTH-1:0]               q8;
  logic [LANES-1:0][DATA_WIDTH-1:0]    lane_q;
  logic signed [OW:0]                  xe, sum, yr;
  logic [OW:0]                         rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: if (lane == LW'(LANES - 1)) state_nxt = WAIT;
      WAIT: state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = (word == WORD_LAST) ? DONE : FILL;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // elem runs continuously across words and parks on the last element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg    <= '0;
      lane   <= '0;
      lane_d <= '0;
      word   <= '0;
      elem   <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= (state == FILL);
      lane_d <= lane;
      case (state)
        IDLE: if (start) begin
          cfg  <= '{shift: cfg_shift, relu: cfg_relu};
          word <= '0;
          elem <= '0;
          lane <= '0;
        end
        FILL: begin
          lane <= lane + LW'(1);
          if (elem != ELEM_LAST) elem <= elem + ADDR_WIDTH'(1);
        end
        HOLD: if (out_ready && word != WORD_LAST) word <= word + WADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Round-half-up shift in OW+1 bits so the rounding add cannot overflow
  always_comb begin
    xe  = $signed({ofm_rd_data[OW-1], ofm_rd_data});
    rnd = (cfg.shift == 4'd0) ? '0 : ({{OW{1'b0}}, 1'b1} << (cfg.shift - 4'd1));
    sum = xe + $signed(rnd);
    yr  = sum >>> cfg.shift;
    if (cfg.relu && yr[OW]) yr = '0;
    if (yr > SAT_MAX)      q8 = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (yr < SAT_MIN) q8 = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                   q8 = yr[DATA_WIDTH-1:0];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ofm_requant_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (rd_vld && (lane_d == LW'(k))),
      .d     (q8),
      .q     (lane_q[k])
    );
  end

  assign ofm_rd_en   = (state == FILL);
  assign ofm_rd_addr = (state == FILL) ? elem : '0;
  assign out_valid   = (state == HOLD);
  assign out_data    = (state == HOLD) ? lane_q : '0;
  assign out_addr    = (state == HOLD) ? word : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
endmodule

// File: tb/tb_ofm_requant_packer.sv
// Randomized bench for ofm_requant_packer: behavioural requant/pack model, backpressure,
// config latching, mid-drain reset and full-drain timing.

module tb_ofm_requant_packer;
  localparam int DW = 8, IW = 128, AW = 15, WAW = 11, LANES = 16;
  localparam int NO_ELEM = 32 * 32 * 32, NO_WORDS = NO_ELEM / LANES;

  logic           clk = 1'b0, rst_n = 1'b1, start = 1'b0, cfg_relu = 1'b0, out_ready = 1'b1;
  logic [3:0]     cfg_shift = '0;
  logic           ofm_rd_en, out_valid, busy, done;
  logic [AW-1:0]  ofm_rd_addr;
  logic [15:0]    ofm_rd_data = '0;
  logic [IW-1:0]  out_data;
  logic [WAW-1:0] out_addr;
  int n_chk = 0, n_fail = 0;
  logic signed [15:0] mem [NO_ELEM];

  ofm_requant_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .ofm_rd_en(ofm_rd_en), .ofm_rd_addr(ofm_rd_addr), .ofm_rd_data(ofm_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ofm_rd_en) ofm_rd_data <= mem[ofm_rd_addr];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fdiv(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] ref_q(input int x, input int s, input bit r);
    int y, d;
    if (s == 0) y = x;
    else begin
      d = 1 << s;
      y = fdiv(x + d / 2, d);
    end
    if (r && y < 0) y = 0;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  function automatic logic [127:0] ref_word(input int w, input int s, input bit r);
    logic [127:0] e;
    e = '0;
    for (int k = 0; k < LANES; k++) e[8*k +: 8] = ref_q(int'(mem[w*LANES + k]), s, r);
    return e;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < NO_ELEM; i++)
      mem[i] = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, ofm_rd_en, 0);
    chk({tag, "_rd_addr"}, ofm_rd_addr, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_addr"}, out_addr, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1 check_idle_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts a drain and follows it until nwords handshakes are scheduled (or done, if to_done).
  // Returns at a negedge; with to_done=0 the last word is still presented.
  task automatic drain(input int nwords, input int s, input bit r, input bit rnd_ready,
                       input bit toggle, input bit to_done, output int words, output int done_cyc);
    int cyc, limit;
    bit fin;
    words = 0; done_cyc = -1; fin = 0;
    limit = to_done ? 40000 : nwords * 80 + 50;
    @(negedge clk);
    cfg_shift = 4'(s); cfg_relu = r; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!fin) begin
      if (out_valid) begin
        chk("data", out_data, ref_word(words, s, r));
        chk("addr", out_addr, words);
        chk("rd_en_hold", ofm_rd_en, 0);
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", busy, 1);
        chk("valid_at_done", out_valid, 0);
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toggle) begin cfg_shift = 4'($urandom); cfg_relu = 1'($urandom); end
      if (out_valid && out_ready) words++;
      if (to_done ? (done_cyc > 0) : (words >= nwords)) fin = 1;
      else if (cyc >= limit) begin
        chk("timeout_words", words, nwords);
        fin = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (to_done) begin
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    int w, dc;
    #2 rst_n = 1'b0;
    #1 check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // s=0: pass-through with saturation
    fill_rand();
    mem[0] = 16'sd100; mem[1] = 16'sd300; mem[2] = -16'sd300; mem[3] = -16'sd128;
    drain(1, 0, 0, 0, 0, 0, w, dc);
    chk("s0_l0", out_data[7:0], 8'h64);
    chk("s0_l1", out_data[15:8], 8'h7F);
    chk("s0_l2", out_data[23:16], 8'h80);
    chk("s0_l3", out_data[31:24], 8'h80);
    apply_reset();

    // s=2 rounding
    mem[0] = 16'sd6; mem[1] = -16'sd6; mem[2] = 16'sd5;
    drain(1, 2, 0, 0, 0, 0, w, dc);
    chk("s2_l0", out_data[7:0], 8'h02);
    chk("s2_l1", out_data[15:8], 8'hFF);
    chk("s2_l2", out_data[23:16], 8'h01);
    apply_reset();

    // s=15 extremes
    mem[0] = 16'sd32767; mem[1] = -16'sd32768;
    drain(1, 15, 0, 0, 0, 0, w, dc);
    chk("s15_l0", out_data[7:0], 8'h01);
    chk("s15_l1", out_data[15:8], 8'hFF);
    apply_reset();

    // ReLU latched; config inputs scrambled every cycle after start
    mem[16] = -16'sd5; mem[17] = 16'sd200;
    drain(2, 0, 1, 0, 1, 0, w, dc);
    chk("relu_l0", out_data[7:0], 8'h00);
    chk("relu_l1", out_data[15:8], 8'h7F);
    apply_reset();

    // Backpressure: word held for 10 cycles, no reads issued
    drain(1, 3, 0, 0, 0, 0, w, dc);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, ref_word(0, 3, 0));
      chk("bp_addr", out_addr, 0);
      chk("bp_rd_en", ofm_rd_en, 0);
    end
    out_ready = 1'b1;
    apply_reset();

    // Randomized drains with random backpressure and config noise
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      drain(6, int'($urandom_range(0, 15)), 1'($urandom), 1, 1, 0, w, dc);
      apply_reset();
    end

    // Reset during FILL of word 5 aborts; next start restarts at word 0
    drain(5, 1, 0, 0, 0, 0, w, dc);
    repeat (3) @(negedge clk);
    chk("mf_rd_en", ofm_rd_en, 1);
    chk("mf_rd_addr", ofm_rd_addr, 5 * LANES + 2);
    rst_n = 1'b0;
    #1 check_idle_zero("midfill");
    @(negedge clk);
    rst_n = 1'b1;
    drain(2, 1, 0, 0, 0, 0, w, dc);
    apply_reset();

    // Full drain, timing of done
    for (int i = 0; i < NO_ELEM; i++) mem[i] = 16'(i % 256);
    drain(NO_WORDS, 0, 0, 0, 0, 1, w, dc);
    chk("full_words", w, NO_WORDS);
    chk("full_done_cycle", dc, 18 * NO_WORDS + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
